// File: rtl/hex_display_counter.sv
// Multi-digit hex display driver with a prescaled up/down counter, per-digit blinking and
// registered active-low 7-segment outputs. Optional leading-zero blanking: HEXDISP_LZ_BLANK_EN.
module hex_display_counter #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    count_en,
    input  logic                    count_up,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    wrap,
    output logic [7*NUM_DIGITS-1:0] hex_out
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h18;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Display of an all-zero value: every digit shows "0", or only digit 0 when blanking leading zeros.
    function automatic logic [HW-1:0] hex_reset_pattern();
        logic [HW-1:0] p;
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef HEXDISP_LZ_BLANK_EN
            p[7*i +: 7] = (i == 0) ? 7'h40 : 7'h7F;
`else
            p[7*i +: 7] = 7'h40;
`endif
        end
        return p;
    endfunction

    localparam logic [HW-1:0] HEX_RST = hex_reset_pattern();

    logic [W-1:0]  value_reg, value_next;
    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic          wrap_reg, wrap_next;
    logic [HW-1:0] hex_reg, hex_next;
    logic          tick;

    assign tick = count_en && (tick_cnt_reg == TICK_LAST);

    always_comb begin
        value_next    = value_reg;
        tick_cnt_next = tick_cnt_reg;
        wrap_next     = 1'b0;
        if (load) begin
            // A load on the same edge as a tick discards the step.
            value_next    = data_in;
            tick_cnt_next = '0;
        end else if (count_en) begin
            if (tick) begin
                tick_cnt_next = '0;
                value_next    = count_up ? value_reg + W'(1) : value_reg - W'(1);
                wrap_next     = count_up ? (value_reg == {W{1'b1}}) : (value_reg == '0);
            end else begin
                tick_cnt_next = tick_cnt_reg + TW'(1);
            end
        end
    end

    always_comb begin
        blink_cnt_next   = blink_cnt_reg + BW'(1);
        blink_phase_next = blink_phase_reg;
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic lz_blank;
`ifdef HEXDISP_LZ_BLANK_EN
        assign lz_blank = (gi != 0) && (value_reg[W-1:4*gi] == '0);
`else
        assign lz_blank = 1'b0;
`endif
        assign hex_next[7*gi +: 7] = (lz_blank || (blink_mask[gi] && blink_phase_reg))
                                     ? 7'h7F : seg7(value_reg[4*gi +: 4]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_reg       <= '0;
            tick_cnt_reg    <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            wrap_reg        <= 1'b0;
            hex_reg         <= HEX_RST;
        end else begin
            value_reg       <= value_next;
            tick_cnt_reg    <= tick_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            wrap_reg        <= wrap_next;
            hex_reg         <= hex_next;
        end
    end

    assign value   = value_reg;
    assign wrap    = wrap_reg;
    assign hex_out = hex_reg;
endmodule

// File: tb/tb_hex_display_counter.sv
// Randomised and scenario-driven check of hex_display_counter against a cycle-level reference model.
module tb_hex_display_counter;
    localparam int ND = 2, TD = 4, BD = 8;

    logic          clk = 1'b0, resetn = 1'b1, load = 1'b0, count_en = 1'b0, count_up = 1'b0;
    logic [7:0]    data_in = '0, value;
    logic [1:0]    blink_mask = '0;
    logic          wrap;
    logic [13:0]   hex_out;

    hex_display_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk(clk), .resetn(resetn), .load(load), .data_in(data_in), .count_en(count_en),
        .count_up(count_up), .blink_mask(blink_mask), .value(value), .wrap(wrap), .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int m_val, m_pre, m_cyc;
    bit m_wrap;
    logic [13:0] m_hex;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef HEXDISP_LZ_BLANK_EN
    localparam logic [13:0] HEX_RST = {7'h7F, 7'h40};
`else
    localparam logic [13:0] HEX_RST = {7'h40, 7'h40};
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] exp_hex(input int v, input bit phase, input logic [1:0] mask);
        logic [13:0] h;
        for (int d = 0; d < ND; d++) begin
            logic [6:0] s;
            s = seg_tab[(v >> (4 * d)) & 15];
`ifdef HEXDISP_LZ_BLANK_EN
            if (d > 0 && (v >> (4 * d)) == 0) s = 7'h7F;
`endif
            if (mask[d] && phase) s = 7'h7F;
            h[7*d +: 7] = s;
        end
        return h;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".value"}, 32'(value), 32'(m_val));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        check({tag, ".hex"}, 32'(hex_out), 32'(m_hex));
    endtask

    // Drives one cycle of inputs, advances the model by one edge and compares.
    task automatic step(input bit ld, input logic [7:0] d, input bit en, input bit up,
                        input logic [1:0] mask);
        bit phase, tick;
        load = ld; data_in = d; count_en = en; count_up = up; blink_mask = mask;
        @(posedge clk);
        #1;
        phase = ((m_cyc / BD) % 2) == 1;
        m_hex = exp_hex(m_val, phase, mask);
        tick  = en && (m_pre == TD - 1);
        if (ld) begin
            m_val = d; m_pre = 0; m_wrap = 0;
        end else if (tick) begin
            m_wrap = up ? (m_val == 255) : (m_val == 0);
            m_val  = (m_val + (up ? 1 : 255)) % 256;
            m_pre  = 0;
        end else begin
            m_wrap = 0;
            if (en) m_pre++;
        end
        m_cyc++;
        $display("cyc %0d ld=%0b d=%h en=%0b up=%0b mask=%b -> value=%h wrap=%0b hex=%h",
                 m_cyc, ld, d, en, up, mask, value, wrap, hex_out);
        check_outputs("step");
    endtask

    task automatic do_reset();
        #3 resetn = 1'b0;
        #1;
        m_val = 0; m_pre = 0; m_cyc = 0; m_wrap = 0; m_hex = HEX_RST;
        check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 check_outputs("reset_held");
        #2 resetn = 1'b1;
    endtask

    initial begin
        m_val = 0; m_pre = 0; m_cyc = 0; m_wrap = 0; m_hex = HEX_RST;
        do_reset();

        // Load and one-cycle-later display.
        step(1, 8'h3A, 0, 0, 2'b00);
        check("load_value", 32'(value), 32'h3A);
        step(0, 8'h00, 0, 0, 2'b00);
        check("load_hex", 32'(hex_out), 32'h1808);

        // Up through FF -> 00 wrap, then down from 00 -> FF wrap.
        step(1, 8'hFE, 0, 1, 2'b00);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 1, 2'b00);
        for (int i = 0; i < 6; i++)  step(0, 8'h00, 1, 0, 2'b00);

        // Load colliding with a tick.
        while (m_pre != TD - 1) step(0, 8'h00, 1, 1, 2'b00);
        step(1, 8'h10, 1, 1, 2'b00);
        check("coll_value", 32'(value), 32'h10);
        check("coll_wrap", 32'(wrap), 32'h0);
        for (int i = 0; i < TD; i++) step(0, 8'h00, 1, 1, 2'b00);
        check("coll_next", 32'(value), 32'h11);

        // Blink on digit 0 only, then no mask.
        step(1, 8'h25, 0, 1, 2'b01);
        for (int i = 0; i < 3 * BD; i++) step(0, 8'h00, 0, 1, 2'b01);
        for (int i = 0; i < BD + 2; i++) step(0, 8'h00, 0, 1, 2'b00);

        // Reset while the prescaler sits at 2, then first step TICK_DIV cycles after release.
        while (m_pre != 2) step(0, 8'h00, 1, 1, 2'b00);
        do_reset();
        for (int i = 0; i < TD; i++) step(0, 8'h00, 1, 1, 2'b00);
        check("rst_mid_value", 32'(value), 32'h01);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 16) == 0, 8'($urandom), ($urandom % 4) != 0, 1'($urandom),
                 2'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
